// File: rtl/nibble_serial_subtracter_if.sv
// Operand/result bus of the nibble-serial subtracter: request side drives
// start and operands, the sequencer returns status and the held result.
interface nibble_serial_subtracter_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         J0;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         J;
   logic         V;

   modport master (
      output start, A, B, J0,
      input  busy, done, D, J, V
   );

   modport slave (
      input  start, A, B, J0,
      output busy, done, D, J, V
   );
endinterface

// File: rtl/nibble_serial_subtracter.sv
// Sequences a W-bit subtraction through an external combinational 4-bit
// full-subtracter slice, one nibble per clock, LSB nibble first.
module nibble_serial_subtracter #(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   nibble_serial_subtracter_if.slave   bus,
   output logic [3:0]                  SA,
   output logic [3:0]                  SB,
   output logic                        SJ0,
   input  logic [3:0]                  SD,
   input  logic                        SJ
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [IW+1:0] bit_lo;
   logic          brw_q;
   logic [W-1:0]  a_r, b_r, d_r;
   logic          j_r, v_r;
   logic          last_nib;

   assign bit_lo   = {idx_q, 2'b00};
   assign last_nib = (idx_q == LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last_nib)  state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // The slice is combinational: its result for nibble idx is captured on the
   // same edge that advances idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         brw_q <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         d_r   <= '0;
         j_r   <= 1'b0;
         v_r   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_r   <= bus.A;
                  b_r   <= bus.B;
                  brw_q <= bus.J0;
                  idx_q <= '0;
               end
            end
            RUN: begin
               d_r[bit_lo +: 4] <= SD;
               brw_q            <= SJ;
               if (last_nib) begin
                  idx_q <= '0;
                  j_r   <= SJ;
                  v_r   <= (a_r[W-1] != b_r[W-1]) && (SD[3] != a_r[W-1]);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      SA       = '0;
      SB       = '0;
      SJ0      = 1'b0;
      bus.busy = (state_q == RUN);
      bus.done = (state_q == FIN);
      bus.D    = d_r;
      bus.J    = j_r;
      bus.V    = v_r;
      if (state_q == RUN) begin
         SA  = a_r[bit_lo +: 4];
         SB  = b_r[bit_lo +: 4];
         SJ0 = brw_q;
      end
   end
endmodule

// File: tb/tb_nibble_serial_subtracter.sv
// Scoreboard bench for nibble_serial_subtracter with a behavioural slice and
// an arithmetic reference model of the wide subtraction.
module tb_nibble_serial_subtracter;
   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct packed {
      logic [W-1:0] d;
      logic         j;
      logic         v;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sa, sb, sd;
   logic       sj0, sj;

   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;
   int   push_cnt = 0;
   res_t exp_q[$];

   nibble_serial_subtracter_if #(.NIBBLES(N)) bus ();

   nibble_serial_subtracter #(.NIBBLES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .SA  (sa),
      .SB  (sb),
      .SJ0 (sj0),
      .SD  (sd),
      .SJ  (sj)
   );

   // External 4-bit full subtracter slice
   always_comb {sj, sd} = {1'b0, sa} - {1'b0, sb} - {4'b0, sj0};

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic j0);
      res_t r;
      int   diff;
      r.d  = a - b - W'(j0);
      r.j  = (longint'(a) < longint'(b) + longint'(j0));
      diff = int'($signed(a)) - int'($signed(b)) - int'(j0);
      r.v  = (diff < -(1 << (W - 1))) || (diff > (1 << (W - 1)) - 1);
      return r;
   endfunction

   // Borrow entering nibble i is whether the low 4*i bits of A are below B's plus J0.
   function automatic logic borrow_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic j0, input int i);
      longint unsigned m;
      if (i == 0) return j0;
      m = (64'd1 << (4 * i)) - 64'd1;
      return (longint'(a) & m) < (longint'(b) & m) + longint'(j0);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check("busy_done_excl", 32'(bus.busy && bus.done), 32'd0);
         if (!bus.busy) check("idle_slice_zero", 32'({sa, sb, sj0}), 32'd0);
         if (bus.done) begin
            res_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("D", 32'(bus.D), 32'(e.d));
               check("J", 32'(bus.J), 32'(e.j));
               check("V", 32'(bus.V), 32'(e.v));
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic j0,
                         input bit spurious);
      res_t e;
      e = model(a, b, j0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.J0    = j0;
      exp_q.push_back(e);
      push_cnt++;
      @(negedge clk);
      bus.start = spurious;
      bus.A     = ~a;
      bus.B     = W'($urandom);
      bus.J0    = ~j0;
      for (int i = 0; i < N; i++) begin
         check("run_busy", 32'(bus.busy), 32'd1);
         check("SA", 32'(sa), 32'(a[4*i +: 4]));
         check("SB", 32'(sb), 32'(b[4*i +: 4]));
         check("SJ0", 32'(sj0), 32'(borrow_into(a, b, j0, i)));
         @(negedge clk);
      end
      check("fin_done", 32'(bus.done), 32'd1);
      check("fin_busy", 32'(bus.busy), 32'd0);
      if (spurious) begin
         @(negedge clk);
         bus.start = 1'b0;
         for (int i = 0; i < 10; i++) begin
            check("hold_done", 32'(bus.done), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd0);
            check("hold_D", 32'(bus.D), 32'(e.d));
            check("hold_JV", 32'({bus.J, bus.V}), 32'({e.j, e.v}));
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.J0    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_D", 32'(bus.D), 32'd0);
      check("rst_JV", 32'({bus.J, bus.V}), 32'd0);
      check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
      check("rst_slice", 32'({sa, sb, sj0}), 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
      run_op(16'h0005, 16'h0005, 1'b1, 1'b1);

      // Abort in the 2nd RUN cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'hABCD;
      bus.B     = 16'h1234;
      bus.J0    = 1'b0;
      exp_q.push_back(model(16'hABCD, 16'h1234, 1'b0));
      push_cnt++;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      void'(exp_q.pop_back());
      push_cnt--;
      @(negedge clk);
      check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
      check("abort_D", 32'(bus.D), 32'd0);
      check("abort_JV", 32'({bus.J, bus.V}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3 * N; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(bus.done), 32'd0);
      end
      run_op(16'hF00D, 16'h0FF1, 1'b1, 1'b0);

      // Start held high: one acceptance every N+2 cycles
      @(negedge clk);
      for (int k = 0; k < 200; k++) begin
         logic [W-1:0] a, b;
         logic         j0;
         a  = W'($urandom);
         b  = W'($urandom);
         j0 = 1'($urandom);
         bus.start = 1'b1;
         bus.A     = a;
         bus.B     = b;
         bus.J0    = j0;
         exp_q.push_back(model(a, b, j0));
         push_cnt++;
         @(negedge clk);
         bus.A  = W'($urandom);
         bus.B  = W'($urandom);
         bus.J0 = 1'($urandom);
         if (k == 199) bus.start = 1'b0;
         repeat (N + 1) @(negedge clk);
      end
      repeat (2 * N) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'(push_cnt));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nibble_serial_subtracter.md
Name: nibble_serial_subtracter

Overview:
- Sequencing stage that wraps the team's 4-bit full subtracter slice and reuses it to compute a 4*NIBBLES-bit difference D = A - B - J0, one nibble per clock, LSB nibble first.
- Latches wide operands on a start pulse and drives nibbles plus the running borrow into the external slice.
- Collects the slice's D/J outputs into a wide result with a done pulse, final borrow and signed-overflow flag.
- Sits directly upstream and downstream of the slice: it feeds SA/SB/SJ0 and consumes SD/SJ.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (operand width W = 4*NIBBLES); legal range 2..16.

Ports:
- clk    input   1     clock; all state changes on rising edge
- rst    input   1     synchronous, active-high reset
- start  input   1     request; sampled only in IDLE
- A      input   W     minuend, captured on accepted start
- B      input   W     subtrahend, captured on accepted start
- J0     input   1     borrow-in, captured on accepted start
- busy   output  1     high while in RUN
- done   output  1     one-cycle pulse, result valid
- D      output  W     difference, held until next accepted start
- J      output  1     final borrow-out, held like D
- V      output  1     two's-complement overflow, held like D
- SA     output  4     nibble of A to slice
- SB     output  4     nibble of B to slice
- SJ0    output  1     borrow-in to slice
- SD     input   4     slice difference
- SJ     input   1     slice borrow-out

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, borrow reg=0, D=0, J=0, V=0, busy=0, done=0. Reset has priority over everything.
- Reset mid-RUN aborts the operation, with no done and no partial result.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge: latch A_r=A, B_r=B, brw=J0, idx=0 -> RUN.
  - Otherwise stay.
  - D/J/V unchanged.
- RUN:
  - Combinationally SA=A_r[4*idx+3:4*idx], SB=B_r[same], SJ0=brw.
  - At each edge: D[4*idx+3:4*idx] <= SD, brw <= SJ, idx <= idx+1.
  - The slice is combinational, so its result is captured in the same cycle it is driven.
- On the edge where idx=NIBBLES-1:
  - Capture the last nibble.
  - J <= SJ.
  - V <= (A_r[W-1] != B_r[W-1]) && (SD[3] != A_r[W-1]).
  - Go to FIN.
- FIN: done=1 for exactly this cycle; next edge -> IDLE.
- Latency: start accepted at edge 0; RUN occupies edges 1..NIBBLES; done is high in the cycle after edge NIBBLES. Next start can be accepted at edge NIBBLES+2 (the first IDLE cycle).
- busy=1 exactly in RUN (NIBBLES cycles); done and busy are never both high.
- start while in RUN or FIN is ignored and not queued.
- A/B/J0 changes after acceptance have no effect.
- Outside RUN: SA=0, SB=0, SJ0=0.
- D is overwritten nibble-by-nibble during RUN, so intermediate D is not valid; only sample it when done=1 or afterwards.
- Arithmetic: {J,D} equals the (W+1)-bit result of A - B - J0 modulo 2^(W+1).
  - J=1 iff A < B + J0 (unsigned).
  - V is evaluated on the W-bit signed interpretation, with J0 included.
- idx width is clog2(NIBBLES); no wrap occurs because the FSM leaves RUN at NIBBLES-1.

Test Plan:
- NIBBLES=4, A=16'h1234, B=16'h0234, J0=0, start pulse -> busy for 4 cycles; SA sequence 4,3,2,1 and SB sequence 4,3,2,0; done one cycle later; D=16'h1000, J=0, V=0.
- A=16'h0000, B=16'h0001, J0=0 -> D=16'hFFFF, J=1, V=0; borrow ripples through all 4 nibbles (SJ0 = 0,1,1,1).
- A=16'h8000, B=16'h0001, J0=0 -> D=16'h7FFF, J=0, V=1. Then A=16'h7FFF, B=16'hFFFF -> D=16'h8000, J=1, V=1.
- A=16'h0005, B=16'h0005, J0=1 -> D=16'hFFFF, J=1, V=0. A second start asserted during RUN and FIN is ignored; exactly one done pulse; D/J/V held stable for 10 idle cycles afterwards.
- Back-to-back: a start held high continuously -> a new operation accepted every NIBBLES+2 cycles; each result is correct against a reference model for 200 random A/B/J0 triples.
- rst asserted at the 2nd RUN cycle -> the next cycle shows IDLE, D=0, J=0, V=0, busy=0, done never pulses; a subsequent start completes normally.
